// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - op and FSM state encodings shared with the main control unit
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIX   = 3'd3,
        ST_WRITE = 3'd4
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [1:0] o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide iteration on {hi, lo}
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_div_i,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    input  logic [DATA_WIDTH-1:0] m_i,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   acc;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;
    logic                  fits;

    always_comb begin
        sum     = {1'b0, hi_i} + {1'b0, m_i};
        acc     = lo_i[0] ? sum : {1'b0, hi_i};
        shifted = {hi_i, lo_i[DATA_WIDTH-1]};
        // Remainder stays below the divisor, so the difference always fits in W bits when it is kept.
        diff    = shifted[DATA_WIDTH-1:0] - m_i;
        fits    = shifted >= {1'b0, m_i};
        if (is_div_i) begin
            hi_o = fits ? diff : shifted[DATA_WIDTH-1:0];
            lo_o = {lo_i[DATA_WIDTH-2:0], fits};
        end else begin
            {hi_o, lo_o} = {acc, lo_i[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multicycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO select and enables
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic                  mthi_req,
    input  logic                  mtlo_req,
    input  logic                  hilo_rd_req,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi_result,
    output logic [DATA_WIDTH-1:0] lo_result,
    output logic                  hi_SEL,
    output logic                  hi_EN,
    output logic                  lo_SEL,
    output logic                  lo_EN,
    output logic                  stall
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    muldiv_state_e           state_q;
    logic [1:0]              op_q;
    logic [DATA_WIDTH-1:0]   hi_q;
    logic [DATA_WIDTH-1:0]   lo_q;
    logic [DATA_WIDTH-1:0]   m_q;
    logic [CW-1:0]           cnt_q;
    logic                    sign_a_q;
    logic                    sign_b_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    dbz_q;

    logic                    is_div;
    logic                    neg_a;
    logic                    neg_b;
    logic [DATA_WIDTH-1:0]   mag_a;
    logic [DATA_WIDTH-1:0]   mag_b;
    logic [2*DATA_WIDTH-1:0] prod_neg;
    logic [DATA_WIDTH-1:0]   step_hi;
    logic [DATA_WIDTH-1:0]   step_lo;

    // hi_q/lo_q hold the raw operands between IDLE and PREP, then serve as the working pair.
    assign is_div   = op_is_div(op_q);
    assign neg_a    = op_is_signed(op_q) & hi_q[DATA_WIDTH-1];
    assign neg_b    = op_is_signed(op_q) & lo_q[DATA_WIDTH-1];
    assign mag_a    = neg_a ? -hi_q : hi_q;
    assign mag_b    = neg_b ? -lo_q : lo_q;
    assign prod_neg = -{hi_q, lo_q};

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .is_div_i (is_div),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        hi_q    <= opA;
                        lo_q    <= opB;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    sign_a_q <= neg_a;
                    sign_b_q <= neg_b;
                    cnt_q    <= CW'(DATA_WIDTH);
                    if (is_div && lo_q == '0) begin
                        lo_q    <= '1;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        m_q     <= is_div ? mag_b : mag_a;
                        hi_q    <= '0;
                        lo_q    <= is_div ? mag_a : mag_b;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!is_div) begin
                        if (sign_a_q ^ sign_b_q) begin
                            {hi_q, lo_q} <= prod_neg;
                        end
                    end else begin
                        if (sign_a_q ^ sign_b_q) begin
                            lo_q <= -lo_q;
                        end
                        if (sign_a_q) begin
                            hi_q <= -hi_q;
                        end
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi_result   = hi_q;
    assign lo_result   = lo_q;
    assign hi_SEL      = done_q;
    assign lo_SEL      = done_q;
    assign hi_EN       = done_q | mthi_req;
    assign lo_EN       = done_q | mtlo_req;
    assign stall       = busy_q & hilo_rd_req;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        mthi_req = 1'b0;
    logic        mtlo_req = 1'b0;
    logic        hilo_rd_req = 1'b0;
    logic        busy, done, div_by_zero, hi_SEL, hi_EN, lo_SEL, lo_EN, stall;
    logic [31:0] hi_result, lo_result;

    typedef struct packed {
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .opA(opA), .opB(opB),
        .mthi_req(mthi_req), .mtlo_req(mtlo_req), .hilo_rd_req(hilo_rd_req),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_result(hi_result), .lo_result(lo_result),
        .hi_SEL(hi_SEL), .hi_EN(hi_EN), .lo_SEL(lo_SEL), .lo_EN(lo_EN), .stall(stall)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t               r;
        logic signed [63:0] sa, sb_, q, rm;
        logic [63:0]        p;
        sa = $signed({{32{a[31]}}, a});
        sb_ = $signed({{32{b[31]}}, b});
        r = '0;
        if (o[1] && b == 32'd0) begin
            r = {1'b1, a, 32'hFFFF_FFFF};
        end else begin
            case (o)
                2'd0: begin p = sa * sb_; r.hi = p[63:32]; r.lo = p[31:0]; end
                2'd1: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
                2'd2: begin q = sa / sb_; rm = sa % sb_; r.hi = rm[31:0]; r.lo = q[31:0]; end
                default: begin r.hi = a % b; r.lo = a / b; end
            endcase
        end
        return r;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input bit push);
        @(negedge CLK);
        op = o; opA = a; opB = b; start = 1'b1;
        if (push) sb.push_back(e);
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (done !== 1'b1 && lat < 100);
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        mthi_req = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({busy, done, div_by_zero, hi_SEL, lo_SEL, stall} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 000000", {busy, done, div_by_zero, hi_SEL, lo_SEL, stall});
        end
        n_cmp++;
        if ({hi_result, lo_result} !== 64'd0) begin
            n_bad++; $display("FAIL reset_result: got %h want 0", {hi_result, lo_result});
        end
        n_cmp++;
        if ({hi_EN, lo_EN} !== 2'b10) begin
            n_bad++; $display("FAIL reset_en: got %b want 10", {hi_EN, lo_EN});
        end
        mthi_req = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_arith();
        vec_t tbl[7] = '{
            '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 35},
            '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 35},
            '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 35},
            '{OP_DIVU,  32'd100,       32'd7,         {1'b0, 32'd2,         32'd14},        35},
            '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0,         32'h8000_0000}, 35},
            '{OP_DIVU,  32'd5,         32'd0,         {1'b1, 32'd5,         32'hFFFF_FFFF}, 2},
            '{OP_DIV,   32'hFFFF_FFF7, 32'd0,         {1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFF}, 2}
        };
        int   lat;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].e, 1'b1);
            wait_done(lat);
            e = sb.pop_front();
            n_cmp++;
            if (lat != tbl[i].lat) begin
                n_bad++; $display("FAIL arith_latency[%0d]: got %0d want %0d", i, lat, tbl[i].lat);
            end
            n_cmp++;
            if ({div_by_zero, hi_result, lo_result} !== e) begin
                n_bad++; $display("FAIL arith_result[%0d]: got %h want %h", i, {div_by_zero, hi_result, lo_result}, e);
            end
            n_cmp++;
            if ({hi_SEL, lo_SEL, hi_EN, lo_EN} !== 4'hF) begin
                n_bad++; $display("FAIL arith_write_ctl[%0d]: got %b want 1111", i, {hi_SEL, lo_SEL, hi_EN, lo_EN});
            end
            @(negedge CLK);
            n_cmp++;
            if ({done, busy, div_by_zero, hi_SEL, hi_EN, lo_EN} !== 6'b0) begin
                n_bad++; $display("FAIL arith_post_write[%0d]: got %b want 000000", i, {done, busy, div_by_zero, hi_SEL, hi_EN, lo_EN});
            end
            n_cmp++;
            if ({hi_result, lo_result} !== {e.hi, e.lo}) begin
                n_bad++; $display("FAIL arith_hold[%0d]: got %h want %h", i, {hi_result, lo_result}, {e.hi, e.lo});
            end
        end
    endtask

    task automatic test_busy_inputs();
        int   lat = 0;
        int   pulses = 0;
        exp_t e;
        issue(OP_MULT, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42}, 1'b1);
        do begin
            @(negedge CLK);
            lat++;
            if (lat == 10) begin
                start = 1'b1; op = OP_DIVU; opA = 32'd1; opB = 32'd0;
                mthi_req = 1'b1; hilo_rd_req = 1'b1;
                #1;
                n_cmp++;
                if ({busy, hi_EN, hi_SEL, lo_EN, stall} !== 5'b11001) begin
                    n_bad++; $display("FAIL busy_mthi: got %b want 11001", {busy, hi_EN, hi_SEL, lo_EN, stall});
                end
            end
            if (lat == 11) begin
                start = 1'b0; mthi_req = 1'b0; hilo_rd_req = 1'b0;
            end
            if (lat == 34) mthi_req = 1'b1;
        end while (done !== 1'b1 && lat < 100);
        e = sb.pop_front();
        n_cmp++;
        if (lat != 35) begin
            n_bad++; $display("FAIL busy_latency: got %0d want 35", lat);
        end
        n_cmp++;
        if ({hi_SEL, hi_EN, div_by_zero, hi_result, lo_result} !== {2'b11, e}) begin
            n_bad++; $display("FAIL busy_write_prio: got %h want %h", {hi_SEL, hi_EN, div_by_zero, hi_result, lo_result}, {2'b11, e});
        end
        mthi_req = 1'b0;
        hilo_rd_req = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if ({pulses, busy, stall} !== {32'd0, 2'b00}) begin
            n_bad++; $display("FAIL busy_start_ignored: got pulses=%0d busy=%b stall=%b want 0 0 0", pulses, busy, stall);
        end
        hilo_rd_req = 1'b0;
    endtask

    task automatic test_reset_abort();
        int   lat;
        int   pulses = 0;
        exp_t e;
        issue(OP_MULTU, 32'd123, 32'd456, '0, 1'b0);
        repeat (16) @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero, hi_SEL, lo_SEL, hi_EN, lo_EN, hi_result, lo_result} !== 71'd0) begin
            n_bad++; $display("FAIL abort_reset_state: got %h want 0", {busy, done, div_by_zero, hi_SEL, lo_SEL, hi_EN, lo_EN, hi_result, lo_result});
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (done === 1'b1 || hi_EN === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++; $display("FAIL abort_no_done: got %0d want 0", pulses);
        end
        issue(OP_DIVU, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, 1'b1);
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++;
        if ({lat, div_by_zero, hi_result, lo_result} !== {35, e}) begin
            n_bad++; $display("FAIL abort_recover: got lat=%0d %h want lat=35 %h", lat, {div_by_zero, hi_result, lo_result}, e);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int          lat, want_lat;
        exp_t        e;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 3) b = 32'd1;
            want_lat = (o[1] && b == 32'd0) ? 2 : 35;
            issue(o, a, b, model(o, a, b), 1'b1);
            wait_done(lat);
            if (sb.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL b2b_scoreboard[%0d]: got empty want entry", i);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (lat != want_lat) begin
                    n_bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, want_lat);
                end
                n_cmp++;
                if ({div_by_zero, hi_result, lo_result} !== e) begin
                    n_bad++; $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, {div_by_zero, hi_result, lo_result}, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_busy_inputs();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and HI/LO register width.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a multiply or divide; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have ports opA, opB  input  DATA_WIDTH  rs and rt values; captured when start is accepted.
REQ-007 SHALL have ports mthi_req, mtlo_req  input  1  main-control request to write HI or LO from rs.
REQ-008 SHALL have port hilo_rd_req  input  1  main control is executing MFHI or MFLO.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when results are written.
REQ-011 SHALL have port div_by_zero  output  1  pulses with done when DIV or DIVU has opB==0.
REQ-012 SHALL have ports hi_result, lo_result  output  DATA_WIDTH  feed the datapath HI/LO mux input 1.
REQ-013 SHALL have ports hi_SEL, hi_EN, lo_SEL, lo_EN  output  1  HI/LO mux select and register enables.
REQ-014 SHALL have port stall  output  1  equals busy AND hilo_rd_req.

Function
REQ-015 The FSM SHALL have states IDLE, PREP, RUN, FIX and WRITE.
REQ-016 IDLE -> PREP SHALL occur when start=1; capture op, opA and opB.
REQ-017 PREP SHALL last 1 cycle: take magnitudes for signed ops, record the sign flags, load the iteration counter with DATA_WIDTH.
REQ-018 PREP -> WRITE SHALL occur directly for a divide with opB==0; otherwise PREP -> RUN.
REQ-019 RUN SHALL last exactly DATA_WIDTH cycles: one shift-add multiply step or one restoring-divide step per cycle, decrementing the counter; counter 1 -> FIX.
REQ-020 FIX SHALL last 1 cycle and apply sign correction.
REQ-021 For MULT, FIX SHALL negate the 2*DATA_WIDTH product when signA XOR signB.
REQ-022 For DIV, FIX SHALL give the quotient sign signA XOR signB and the remainder sign signA.
REQ-023 WRITE SHALL last 1 cycle with done=1, hi_SEL=lo_SEL=1 and hi_EN=lo_EN=1, then return to IDLE.
REQ-024 Multiply results SHALL be HI=product[2W-1:W] and LO=product[W-1:0].
REQ-025 Divide results SHALL be HI=remainder and LO=quotient.
REQ-026 For divide-by-zero, the block SHALL write HI=opA and LO=all ones, with div_by_zero=1 in WRITE.
REQ-027 DIV of 0x80000000 by 0xFFFFFFFF SHALL wrap: LO=0x80000000, HI=0.
REQ-028 Normal latency SHALL be: done high in the 35th cycle after the edge sampling start (DATA_WIDTH=32).
REQ-029 Divide-by-zero latency SHALL be: done high in the 2nd cycle after that edge.
REQ-030 start while busy SHALL be ignored; no queuing.
REQ-031 Outside WRITE: hi_SEL=lo_SEL=0, hi_EN=mthi_req, lo_EN=mtlo_req.
REQ-032 In WRITE, the sequencer SHALL have priority and mthi_req/mtlo_req SHALL be dropped.
REQ-033 hi_result and lo_result SHALL hold their value after WRITE until the next accepted start.

Reset
REQ-034 On RST=0, asynchronously: state=IDLE, counter=0, all internal registers=0.
REQ-035 On RST=0, all outputs SHALL be 0 except hi_EN/lo_EN, which follow REQ-031.
REQ-036 Reset during PREP, RUN or FIX SHALL abort the operation with no HI/LO write and no done pulse.

Structure
REQ-037 The op encodings and FSM state encodings SHALL live in the shared processor package, used by the main control unit.
REQ-038 One sub-module, muldiv_step, SHALL be natural: the combinational single-iteration add/subtract-shift datapath.
REQ-039 hi/lo registers SHALL remain in the datapath; this block SHALL only drive their select and enable lines.

Verification
REQ-040 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 35, HI=0xFFFFFFFE, LO=0x00000001, hi_EN=lo_EN=1 for one cycle.
REQ-041 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-042 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-043 DIVU 5 / 0 -> done and div_by_zero at cycle 2, HI=5, LO=0xFFFFFFFF.
REQ-044 Second start and mthi_req at cycle 10 of a MULT -> start ignored, hi_EN=1 that cycle; mthi_req in WRITE -> hi_SEL=1; hilo_rd_req while busy -> stall=1.
REQ-045 RST low at RUN cycle 15 -> busy=0 immediately, no done pulse, next start completes normally.
